// File: rtl/store_buf_pkg.sv
// store_buf_pkg
// Shared types and helpers for the posted-write store buffer.
//   store_size_e     : RV32 store width taken from funct3[1:0]
//   store_entry_t    : one queued write (word address, lane data, byte strobe)
//   drain_state_e    : states of the drain FSM that feeds the write master
//   store_misaligned : true when a store cannot be expressed as one aligned word write
//   align_store      : word-aligns the address and replicates data onto the byte lanes
package store_buf_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_STRB_W = SB_DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } store_size_e;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_STRB_W-1:0] strb;
  } store_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GUARD = 2'b10,
    WAIT  = 2'b11
  } drain_state_e;

  function automatic logic store_misaligned(input store_size_e size,
                                            input logic [1:0]  lsb);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      SZ_WORD: bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Data is replicated across every lane so the strobe alone selects the bytes.
  function automatic store_entry_t align_store(input logic [SB_ADDR_W-1:0] addr,
                                               input logic [SB_DATA_W-1:0] data,
                                               input store_size_e          size);
    store_entry_t e;
    e.addr = {addr[SB_ADDR_W-1:2], 2'b00};
    case (size)
      SZ_BYTE: begin
        e.data = {4{data[7:0]}};
        e.strb = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        e.data = {2{data[15:0]}};
        e.strb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        e.data = data;
        e.strb = 4'b1111;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/store_buf_fifo.sv
// store_buf_fifo
// Circular FIFO of store_entry_t with an extra tail-write port used for
// store merging. Pointers wrap naturally because DEPTH is a power of two.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (clears all entries)
//   push, push_entry  : append an entry (caller guarantees not full)
//   pop               : drop the head entry (caller guarantees not empty)
//   merge, merge_entry: fold strobed lanes of merge_entry into the tail entry
//   head, tail        : current oldest / youngest entry
//   count             : number of occupied entries
module store_buf_fifo
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  store_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   merge,
  input  store_entry_t           merge_entry,
  output store_entry_t           head,
  output store_entry_t           tail,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  store_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tail_ptr;
  store_entry_t     merged;

  assign tail_ptr = wr_ptr - PTR_W'(1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];

  // Lanes enabled by the new store replace the old bytes; strobes accumulate.
  always_comb begin
    merged      = tail;
    merged.strb = tail.strb | merge_entry.strb;
    for (int b = 0; b < SB_STRB_W; b++) begin
      if (merge_entry.strb[b]) begin
        merged.data[8*b +: 8] = merge_entry.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end else if (merge) begin
        mem[tail_ptr] <= merged;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_store_buffer.sv
// axi_store_buffer
// Posted-write buffer between the CPU memory stage and the AXI4-Lite write
// master. RV32 stores are aligned into (word address, lane data, strobe),
// queued in store_buf_fifo and issued one at a time by a drain FSM.
// Optional feature macro: STORE_BUF_MERGE_EN (merge same-word stores into the tail).
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   store_valid/addr/data/size    : store request from the memory stage
//   store_ready                   : a store can be accepted this cycle
//   misalign_err                  : one-cycle pulse after a dropped store
//   write_start                   : one-cycle issue pulse to the write master
//   write_addr/data/strobe        : registered head entry, held until next issue
//   write_busy                    : write master transaction in progress
//   buf_empty, buf_count          : occupancy status
module axi_store_buffer
  import store_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   store_valid,
  input  logic [ADDR_WIDTH-1:0]  store_addr,
  input  logic [DATA_WIDTH-1:0]  store_data,
  input  logic [1:0]             store_size,
  output logic                   store_ready,
  output logic                   misalign_err,
  output logic                   write_start,
  output logic [ADDR_WIDTH-1:0]  write_addr,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic [3:0]             write_strobe,
  input  logic                   write_busy,
  output logic                   buf_empty,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int               CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

`ifdef STORE_BUF_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  drain_state_e     state;
  store_size_e      size;
  store_entry_t     aligned;
  store_entry_t     head;
  store_entry_t     tail;
  logic [CNT_W-1:0] count;
  logic             legal;
  logic             accept;
  logic             launch;
  logic             merge_block;
  logic             merge_hit;
  logic             push;
  logic             merge;
  logic             pop;

  assign size    = store_size_e'(store_size);
  assign legal   = !store_misaligned(size, store_addr[1:0]);
  assign aligned = align_store(SB_ADDR_W'(store_addr), SB_DATA_W'(store_data), size);

  // launch: the FSM latches the head into the write registers at the next edge.
  assign launch = (state == IDLE) && (count != '0) && !write_busy;

  // With a single entry the tail is the head. Merging is refused both while it
  // is being latched for issue and while it is being popped, otherwise the new
  // bytes would land in an entry that has already been sent.
  assign merge_block = (count == ONE) && (launch || (state == ISSUE));
  assign merge_hit   = MERGE_EN && legal && (count != '0) &&
                       (tail.addr == aligned.addr) && !merge_block;

  assign store_ready = (count != FULL) || merge_hit;
  assign accept      = store_valid && store_ready;
  assign push        = accept && legal && !merge_hit;
  assign merge       = accept && legal && merge_hit;
  assign pop         = (state == ISSUE);

  assign buf_count = count;
  assign buf_empty = (count == '0) && (state == IDLE);

  store_buf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (aligned),
    .pop        (pop),
    .merge      (merge),
    .merge_entry(aligned),
    .head       (head),
    .tail       (tail),
    .count      (count)
  );

  // Drain FSM. The write registers load on the IDLE->ISSUE edge, so the
  // entry is presented in the same cycle write_start is high and the FIFO
  // pops it in that cycle. GUARD covers the cycle before the master raises busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      write_start  <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      write_strobe <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= accept && !legal;
      write_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state        <= ISSUE;
            write_start  <= 1'b1;
            write_addr   <= ADDR_WIDTH'(head.addr);
            write_data   <= DATA_WIDTH'(head.data);
            write_strobe <= head.strb;
          end
        end
        ISSUE:   state <= GUARD;
        GUARD:   state <= WAIT;
        WAIT: begin
          if (!write_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_store_buffer.sv
// tb_axi_store_buffer
// Directed bench for axi_store_buffer (default DEPTH=4). Each task drives one
// scenario and compares outputs against hand-computed values.
module tb_axi_store_buffer;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b1;
  logic        store_valid  = 1'b0;
  logic [31:0] store_addr   = '0;
  logic [31:0] store_data   = '0;
  logic [1:0]  store_size   = '0;
  logic        write_busy   = 1'b0;
  logic        store_ready;
  logic        misalign_err;
  logic        write_start;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        buf_empty;
  logic [2:0]  buf_count;

  int checks   = 0;
  int failures = 0;

  // {write_start, misalign_err, buf_empty, store_ready, buf_count, strobe, addr, data}
  localparam logic [74:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0, 32'd0, 32'd0};

  always #5 clk = ~clk;

  axi_store_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .store_valid (store_valid),
    .store_addr  (store_addr),
    .store_data  (store_data),
    .store_size  (store_size),
    .store_ready (store_ready),
    .misalign_err(misalign_err),
    .write_start (write_start),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_strobe(write_strobe),
    .write_busy  (write_busy),
    .buf_empty   (buf_empty),
    .buf_count   (buf_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    store_valid = 1'b1;
    store_addr  = a;
    store_data  = d;
    store_size  = sz;
    tick();
    store_valid = 1'b0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (write_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_empty(output bit done);
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (buf_empty === 1'b1) begin
        done = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({write_start, misalign_err, buf_empty, store_ready, buf_count, write_strobe, write_addr, write_data} !== RESET_VEC) begin
      failures++;
      $display("[TB] FAIL reset_values: got %h expected %h",
               {write_start, misalign_err, buf_empty, store_ready, buf_count, write_strobe, write_addr, write_data}, RESET_VEC);
    end
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word();
    bit ok;
    do_store(32'h04, 32'hDEADBEEF, 2'b10);
    checks++;
    if ({write_start, buf_count} !== {1'b0, 3'd1}) begin
      failures++;
      $display("[TB] FAIL word_queued: start,count got %b,%0d expected 0,1", write_start, buf_count);
    end
    tick();
    checks++;
    if ({write_start, write_addr, write_data, write_strobe} !== {1'b1, 32'h04, 32'hDEADBEEF, 4'b1111}) begin
      failures++;
      $display("[TB] FAIL word_issue: got start=%b addr=%h data=%h strb=%b expected 1 00000004 deadbeef 1111",
               write_start, write_addr, write_data, write_strobe);
    end
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL word_drain: buf_empty got 0 expected 1");
    end
  endtask

  task automatic test_byte_half();
    bit ok;
    do_store(32'h0B, 32'h000000AB, 2'b00);
    wait_start(ok);
    checks++;
    if (!ok || {write_addr, write_data, write_strobe} !== {32'h08, 32'hABABABAB, 4'b1000}) begin
      failures++;
      $display("[TB] FAIL byte_issue: got seen=%0d addr=%h data=%h strb=%b expected 00000008 abababab 1000",
               ok, write_addr, write_data, write_strobe);
    end
    wait_empty(ok);
    do_store(32'h0E, 32'h00001234, 2'b01);
    wait_start(ok);
    checks++;
    if (!ok || {write_addr, write_data, write_strobe} !== {32'h0C, 32'h12341234, 4'b1100}) begin
      failures++;
      $display("[TB] FAIL half_issue: got seen=%0d addr=%h data=%h strb=%b expected 0000000c 12341234 1100",
               ok, write_addr, write_data, write_strobe);
    end
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL half_drain: buf_empty got 0 expected 1");
    end
  endtask

  task automatic test_misaligned();
    int starts = 0;
    do_store(32'h05, 32'h0000BEEF, 2'b01);
    checks++;
    if ({misalign_err, buf_count} !== {1'b1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL misalign_half: err,count got %b,%0d expected 1,0", misalign_err, buf_count);
    end
    do_store(32'h02, 32'h01020304, 2'b10);
    checks++;
    if ({misalign_err, buf_count} !== {1'b1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL misalign_word: err,count got %b,%0d expected 1,0", misalign_err, buf_count);
    end
    do_store(32'h0C, 32'hCAFEF00D, 2'b11);
    checks++;
    if ({misalign_err, buf_count} !== {1'b1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL misalign_illegal: err,count got %b,%0d expected 1,0", misalign_err, buf_count);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (write_start === 1'b1) starts++;
    end
    checks++;
    if ({misalign_err, buf_count, buf_empty, starts[3:0]} !== {1'b0, 3'd0, 1'b1, 4'd0}) begin
      failures++;
      $display("[TB] FAIL misalign_quiet: err=%b count=%0d empty=%b starts=%0d expected 0 0 1 0",
               misalign_err, buf_count, buf_empty, starts);
    end
  endtask

  task automatic test_full();
    logic [31:0] sa [5] = '{32'h100, 32'h104, 32'h10B, 32'h10E, 32'h111};
    logic [31:0] sd [5] = '{32'h11111111, 32'h22222222, 32'h33, 32'h4444, 32'h55};
    logic [1:0]  sz [5] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [67:0] ev [5] = '{{32'h100, 32'h11111111, 4'b1111},
                            {32'h104, 32'h22222222, 4'b1111},
                            {32'h108, 32'h33333333, 4'b1000},
                            {32'h10C, 32'h44444444, 4'b1100},
                            {32'h110, 32'h55555555, 4'b0010}};
    int   issued  = 0;
    bit   pending = 1'b0;
    logic [2:0] acc_count = '0;
    write_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_store(sa[i], sd[i], sz[i]);
    end
    checks++;
    if ({buf_count, store_ready} !== {3'd4, 1'b0}) begin
      failures++;
      $display("[TB] FAIL full_flag: count,ready got %0d,%b expected 4,0", buf_count, store_ready);
    end
    store_valid = 1'b1;
    store_addr  = sa[4];
    store_data  = sd[4];
    store_size  = sz[4];
    tick();
    tick();
    checks++;
    if ({buf_count, write_start} !== {3'd4, 1'b0}) begin
      failures++;
      $display("[TB] FAIL full_hold: count,start got %0d,%b expected 4,0", buf_count, write_start);
    end
    write_busy = 1'b0;
    for (int cyc = 0; cyc < 80 && issued < 5; cyc++) begin
      if (write_start === 1'b1) begin
        checks++;
        if ({write_addr, write_data, write_strobe} !== ev[issued]) begin
          failures++;
          $display("[TB] FAIL drain_order[%0d]: got %h expected %h", issued,
                   {write_addr, write_data, write_strobe}, ev[issued]);
        end
        if (issued == 0) begin
          checks++;
          if ({store_ready, buf_count} !== {1'b0, 3'd4}) begin
            failures++;
            $display("[TB] FAIL full_during_pop: ready,count got %b,%0d expected 0,4", store_ready, buf_count);
          end
        end
        issued++;
      end
      if (store_valid && store_ready === 1'b1) begin
        pending   = 1'b1;
        acc_count = buf_count;
      end
      tick();
      if (pending) begin
        pending     = 1'b0;
        store_valid = 1'b0;
        checks++;
        if (acc_count !== 3'd3) begin
          failures++;
          $display("[TB] FAIL fifth_accept: count at accept got %0d expected 3", acc_count);
        end
      end
    end
    store_valid = 1'b0;
    checks++;
    if (issued != 5) begin
      failures++;
      $display("[TB] FAIL drain_count: issued got %0d expected 5", issued);
    end
    wait_empty(pending);
  endtask

  task automatic test_merge();
    bit ok;
    write_busy = 1'b1;
    do_store(32'h20, 32'h11, 2'b00);
    do_store(32'h21, 32'h22, 2'b00);
`ifdef STORE_BUF_MERGE_EN
    checks++;
    if (buf_count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL merge_count: got %0d expected 1", buf_count);
    end
    write_busy = 1'b0;
    wait_start(ok);
    checks++;
    if (!ok || {write_addr, write_data[15:0], write_strobe} !== {32'h20, 16'h2211, 4'b0011}) begin
      failures++;
      $display("[TB] FAIL merge_issue: got seen=%0d addr=%h data=%h strb=%b expected 00000020 xxxx2211 0011",
               ok, write_addr, write_data, write_strobe);
    end
`else
    checks++;
    if (buf_count !== 3'd2) begin
      failures++;
      $display("[TB] FAIL nomerge_count: got %0d expected 2", buf_count);
    end
    write_busy = 1'b0;
    wait_start(ok);
    checks++;
    if (!ok || {write_addr, write_data, write_strobe} !== {32'h20, 32'h11111111, 4'b0001}) begin
      failures++;
      $display("[TB] FAIL nomerge_first: got seen=%0d addr=%h data=%h strb=%b expected 00000020 11111111 0001",
               ok, write_addr, write_data, write_strobe);
    end
    tick();
    wait_start(ok);
    checks++;
    if (!ok || {write_addr, write_data, write_strobe} !== {32'h20, 32'h22222222, 4'b0010}) begin
      failures++;
      $display("[TB] FAIL nomerge_second: got seen=%0d addr=%h data=%h strb=%b expected 00000020 22222222 0010",
               ok, write_addr, write_data, write_strobe);
    end
`endif
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL merge_drain: buf_empty got 0 expected 1");
    end
  endtask

  task automatic test_reset_mid_op();
    int starts = 0;
    write_busy = 1'b1;
    do_store(32'h40, 32'hA0A0A0A0, 2'b10);
    do_store(32'h44, 32'hA1A1A1A1, 2'b10);
    do_store(32'h48, 32'hA2A2A2A2, 2'b10);
    do_store(32'h4C, 32'hA3A3A3A3, 2'b10);
    write_busy = 1'b0;
    tick();
    write_busy = 1'b1;
    tick();
    tick();
    checks++;
    if ({buf_count, buf_empty, write_start, write_addr} !== {3'd3, 1'b0, 1'b0, 32'h40}) begin
      failures++;
      $display("[TB] FAIL pre_reset_state: count=%0d empty=%b start=%b addr=%h expected 3 0 0 00000040",
               buf_count, buf_empty, write_start, write_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({write_start, misalign_err, buf_empty, store_ready, buf_count, write_strobe, write_addr, write_data} !== RESET_VEC) begin
      failures++;
      $display("[TB] FAIL async_reset: got %h expected %h",
               {write_start, misalign_err, buf_empty, store_ready, buf_count, write_strobe, write_addr, write_data}, RESET_VEC);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    write_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write_start === 1'b1) starts++;
    end
    checks++;
    if ({starts[3:0], buf_empty, buf_count} !== {4'd0, 1'b1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL post_reset_lost: starts=%0d empty=%b count=%0d expected 0 1 0",
               starts, buf_empty, buf_count);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_full();
    test_merge();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
